audio_pwm_out: RTL
==================

# audio_pwm_out

Audio output stage that consumes the filter's per-sample 8-bit signed output and drives a single-bit PWM pin for an external RC low-pass. It sits after the state-variable filter and the output mixer. It accepts the same `sample_valid` strobe convention, with no back-pressure. A one-deep pending buffer decouples the sample rate from the PWM frame rate. Sticky flags report overrun and underrun.

## Interface
- `PWM_BITS`, default 8: counter width; frame length is 2^PWM_BITS clocks. It must be at least 8. The sample's 8 bits are MSB-aligned and the lower bits are zero-filled.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low. There is one clock and reset is asynchronous active-low.
- `enable`, input, 1: run the PWM. When 0, the block is held idle.
- `audio_in`, input, 8 (signed): sample from the filter or mixer.
- `sample_valid`, input, 1: single-cycle strobe; `audio_in` is valid in that cycle.
- `clear_flags`, input, 1: clears `overrun` and `underrun`. It has priority over a set in the same cycle.
- `pwm_out`, output, 1: registered PWM output.
- `frame_start`, output, 1: registered one-cycle pulse aligned with the first `pwm_out` bit of each frame.
- `overrun`, output, 1: sticky; a pending sample was lost.
- `underrun`, output, 1: sticky; a frame boundary arrived with no new sample.

## Operation
- **Offset conversion.** `duty = {audio_in ^ 8'h80, (PWM_BITS-8)'b0}`. Resulting duty:
  - -128 gives 0 (always low).
  - 0 gives midscale.
  - +127 gives 255/256 high when PWM_BITS is 8.
- **Pending buffer.** On `sample_valid`, the converted sample is written to `pending` and `pending_valid` is set to 1. If `pending_valid` was already 1, the old sample is overwritten and `overrun` is set.
- **Frame counter.** `cnt` counts 0 .. 2^PWM_BITS-1 and wraps. The load cycle is the cycle with `cnt` at all-ones.
- **Load cycle.** The active duty register (`active`) is updated as follows:
  - If `sample_valid` is 1: `active` takes the converted `audio_in` directly (bypass). If `pending_valid` was also 1, `overrun` is set.
  - Else if `pending_valid` is 1: `active` takes `pending`.
  - Else: `active` is held and `underrun` is set.
  - `pending_valid` is cleared in every load cycle.
- **Compare.** `pwm_out` in cycle t+1 equals `enable(t) && cnt(t) < active(t)`.
- **Disable** (`enable` = 0):
  - `cnt` is forced to 0.
  - `active` is forced to midscale.
  - `pending_valid` is cleared.
  - `pwm_out` and `frame_start` go low on the next cycle.
  - Flags hold, and no flags are set.
  - When `enable` rises, the first frame starts at `cnt` = 0 with midscale duty.
- **Reset values:**
  - `pwm_out`, `frame_start`, `overrun`, `underrun` = 0.
  - `cnt` = 0.
  - `active` = midscale (8'h80 aligned).
  - `pending_valid` = 0.

## Timing
- **Output latency.** `pwm_out` and `frame_start` are one register after the counter. `frame_start` is high in the cycle after `cnt` = 0.
- **Sample-to-output latency.**
  - A sample accepted in frame N is played in frame N+1.
  - A sample strobed in the load cycle of frame N is also played in frame N+1.
  - Minimum latency is 2 clocks: strobe in the load cycle, then the first output bit.
  - Maximum latency is 2^PWM_BITS + 1 clocks.
- **Sustained rate.** At most one sample per frame is played without loss. Slower sample rates repeat the last sample and raise `underrun`.
- **Reset mid-frame.** All state takes its reset value immediately and asynchronously; the pending sample is discarded.
- **Flag timing.** Flags assert in the cycle after the triggering event.

## Configuration
- **`AUDIO_PWM_BITREV_EN` defined:** the compare uses the bit-reversed counter, `bitrev(cnt) < active`. The number of high cycles per frame is unchanged, but the highs are spread across the frame, which moves ripple energy up toward clk/2.
- **Undefined:** plain counter compare; each frame has one contiguous high pulse starting at `cnt` = 0.
- **In both cases:** flags, the buffer, `frame_start`, and all latencies are identical.

## Structure
- **Shared package `audio_pkg`:**
  - `AUDIO_W` = 8.
  - `AUDIO_MIDSCALE` = 8'h80.
  - Function `audio_to_offset` (signed to offset-binary).
  - `typedef logic signed [7:0] audio_t`.
- **Sub-module `audio_pwm_sample_buf`:** holds the pending register, `pending_valid`, the load-cycle source select, and overrun/underrun flag logic.
- **Top level:** counter, optional bit-reverse, compare, output registers.

## Test plan
- **Reset then enable with no samples:** 128 high cycles per 256-cycle frame; `underrun` = 1 after the first load cycle; `overrun` = 0; `frame_start` period = 256.
- **Extreme samples:**
  - +127 (8'h7F) → next frame has 255 high cycles.
  - -128 (8'h80) → next frame `pwm_out` stays 0.
  - 0 → 128 high cycles.
- **Two strobes in one frame, 8'h10 then 8'h20:** `overrun` = 1; next frame has 160 high cycles. `clear_flags` clears the flag, and `clear_flags` coincident with a new overrun leaves it 0.
- **Strobe exactly on the load cycle with 8'h40:** the following frame has 192 high cycles; no `underrun`. Repeat with a pending sample also present: 192 high cycles and `overrun` = 1.
- **`rst_n` pulsed low at `cnt` = 100 with a pending sample:** `pwm_out` = 0 asynchronously; after release, first frame is midscale and `underrun` sets at its end.
- **`enable` dropped at `cnt` = 50, then restored:** `pwm_out` = 0 the next cycle; restart frame is midscale from `cnt` = 0. With `AUDIO_PWM_BITREV_EN`, each frame still has the same high-cycle count as without the macro.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample type, width, midscale and offset conversion.
package audio_pkg;

  localparam int unsigned AUDIO_W = 8;
  localparam logic [AUDIO_W-1:0] AUDIO_MIDSCALE = 8'h80;

  typedef logic signed [AUDIO_W-1:0] audio_t;

  // Where the next active duty comes from in a load cycle
  typedef enum logic [1:0] {
    SRC_HOLD    = 2'd0,
    SRC_PENDING = 2'd1,
    SRC_BYPASS  = 2'd2
  } load_src_e;

  // Two's-complement sample to offset binary (-128 -> 0, 0 -> 0x80, +127 -> 0xFF)
  function automatic logic [AUDIO_W-1:0] audio_to_offset(input audio_t s);
    return $unsigned(s) ^ AUDIO_MIDSCALE;
  endfunction

endpackage

// File: rtl/audio_pwm_sample_buf.sv
// One-deep pending sample buffer, load-cycle source select and sticky overrun/underrun flags.
module audio_pwm_sample_buf
  import audio_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               load_cycle,
  input  logic               sample_valid,
  input  logic signed [AUDIO_W-1:0] audio_in,
  input  logic               clear_flags,
  output logic               load_en_c,
  output logic [AUDIO_W-1:0] load_duty_c,
  output logic               overrun,
  output logic               underrun
);

  logic [AUDIO_W-1:0] pending_q, pending_d;
  logic               pending_valid_q, pending_valid_d;
  logic               overrun_q, overrun_d;
  logic               underrun_q, underrun_d;
  logic [AUDIO_W-1:0] sample_off;
  load_src_e          src_c;
  logic               ov_set, un_set;

  // Offset-binary view of the incoming sample
  always_comb sample_off = audio_to_offset(audio_in);

  // Buffer update and load-cycle source decision; disable drops any pending sample
  always_comb begin
    src_c           = SRC_HOLD;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    ov_set          = 1'b0;
    un_set          = 1'b0;
    if (!enable) begin
      pending_valid_d = 1'b0;
    end else if (load_cycle) begin
      pending_valid_d = 1'b0;
      if (sample_valid) begin
        src_c  = SRC_BYPASS;
        ov_set = pending_valid_q;
      end else if (pending_valid_q) begin
        src_c = SRC_PENDING;
      end else begin
        un_set = 1'b1;
      end
    end else if (sample_valid) begin
      pending_d       = sample_off;
      pending_valid_d = 1'b1;
      ov_set          = pending_valid_q;
    end
  end

  // Duty handed to the active register in the load cycle
  always_comb begin
    load_en_c   = 1'b0;
    load_duty_c = pending_q;
    case (src_c)
      SRC_BYPASS: begin
        load_en_c   = 1'b1;
        load_duty_c = sample_off;
      end
      SRC_PENDING: load_en_c = 1'b1;
      default: ;
    endcase
  end

  // Sticky flags; a clear wins over a set in the same cycle
  always_comb begin
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    if (clear_flags) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end else begin
      if (ov_set) overrun_d  = 1'b1;
      if (un_set) underrun_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      overrun_q       <= 1'b0;
      underrun_q      <= 1'b0;
    end else begin
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      overrun_q       <= overrun_d;
      underrun_q      <= underrun_d;
    end
  end

  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule

// File: rtl/audio_pwm_out.sv
// Audio PWM output stage: frame counter, duty compare and registered outputs.
// Define AUDIO_PWM_BITREV_EN to compare against the bit-reversed counter,
// spreading the high cycles across the frame with the same count per frame.
module audio_pwm_out
  import audio_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic signed [AUDIO_W-1:0] audio_in,
  input  logic                      sample_valid,
  input  logic                      clear_flags,
  output logic                      pwm_out,
  output logic                      frame_start,
  output logic                      overrun,
  output logic                      underrun
);

  localparam int unsigned PAD_W = PWM_BITS - AUDIO_W;
  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
  localparam logic [PWM_BITS-1:0] DUTY_MID = PWM_BITS'(AUDIO_MIDSCALE) << PAD_W;

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] active_q, active_d;
  logic                pwm_out_q, pwm_out_d;
  logic                frame_start_q, frame_start_d;
  logic [PWM_BITS-1:0] cmp_cnt;
  logic                load_cycle;
  logic                load_en_c;
  logic [AUDIO_W-1:0]  load_duty_c;

  audio_pwm_sample_buf u_sample_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .load_cycle   (load_cycle),
    .sample_valid (sample_valid),
    .audio_in     (audio_in),
    .clear_flags  (clear_flags),
    .load_en_c    (load_en_c),
    .load_duty_c  (load_duty_c),
    .overrun      (overrun),
    .underrun     (underrun)
  );

`ifdef AUDIO_PWM_BITREV_EN
  for (genvar i = 0; i < PWM_BITS; i++) begin : g_bitrev
    assign cmp_cnt[i] = cnt_q[PWM_BITS-1-i];
  end
`else
  assign cmp_cnt = cnt_q;
`endif

  // Last cycle of each frame is where the next duty is taken
  always_comb load_cycle = enable && (cnt_q == CNT_MAX);

  // Counter, active duty and output next-state; disable parks everything at frame start, midscale
  always_comb begin
    cnt_d         = '0;
    active_d      = DUTY_MID;
    pwm_out_d     = 1'b0;
    frame_start_d = 1'b0;
    if (enable) begin
      cnt_d         = cnt_q + PWM_BITS'(1);
      active_d      = load_en_c ? (PWM_BITS'(load_duty_c) << PAD_W) : active_q;
      pwm_out_d     = (cmp_cnt < active_q);
      frame_start_d = (cnt_q == '0);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      active_q      <= DUTY_MID;
      pwm_out_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      active_q      <= active_d;
      pwm_out_q     <= pwm_out_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pwm_out     = pwm_out_q;
  assign frame_start = frame_start_q;

endmodule
